// File: rtl/rr_arbiter_4_encoded.sv
// ---------------------------------------------------------------------------
// rr_arbiter_4_encoded
//
// Round-robin arbiter sharing one downstream resource among four requesters.
// A winner receives a registered one-hot grant plus its 2-bit encoded index
// (0001->00, 0010->01, 0100->10, 1000->11). Tenure ends on done, on the
// grantee dropping its request, or on the hold limit. After every release
// there is one GAP cycle and one IDLE cycle with no grant, which gives
// downstream select logic a dead cycle to switch.
//
// Parameters:
//   MAX_HOLD   maximum grant tenure in cycles (legal range 2..255)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset, synchronous release
//   req[3:0]   request lines, bit i held by requester i while it wants/uses
//   done       completion strobe from the current grantee (GRANT only)
//   gnt[3:0]   one-hot grant, registered, 0000 when idle
//   gnt_idx    encoded grant index, 00 when no grant
//   gnt_valid  high while gnt is non-zero
//   timeout    one-cycle pulse after a hold-limit revoke
// ---------------------------------------------------------------------------
module rr_arbiter_4_encoded #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // hold_cnt counts edges since the grant was loaded; reaching this value
  // means the grant has been visible for MAX_HOLD cycles.
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;

  // Requests rotated so that bit 0 is the highest-priority requester (ptr).
  logic [3:0] rot_req;
  logic [1:0] pick_off;
  logic [1:0] pick_idx;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rotate
      assign rot_req[gi] = req[ptr + 2'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the first requester in search
  // order; iterate downward so the lowest index wins.
  always_comb begin
    pick_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) begin
        pick_off = 2'(k);
      end
    end
  end

  assign pick_idx = ptr + pick_off;

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Exit conditions of a tenure; done has priority over drop, drop over limit.
  logic grantee_req;
  logic hold_expired;
  logic release_now;

  assign grantee_req  = req[gnt_idx];
  assign hold_expired = (hold_cnt == HOLD_LIMIT);
  assign release_now  = done || !grantee_req || hold_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= 8'd0;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= GRANT;
            gnt       <= idx_to_onehot(pick_idx);
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= 8'd0;
          end
        end

        GRANT: begin
          if (release_now) begin
            state     <= GAP;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
            // Only a pure hold-limit exit reports a timeout; a coincident
            // done or drop counts as an ordinary release.
            timeout   <= !done && grantee_req;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        GAP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4_encoded.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_4_encoded
//
// Self-checking bench for rr_arbiter_4_encoded. A behavioural model tracks
// the current owner, how many cycles it has been visible, whether the
// post-release gap is pending, and the priority pointer; directed scenario
// tasks and a randomized run compare the DUT against it every cycle.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_4_encoded;

  localparam int MAX_HOLD = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_arbiter_4_encoded #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   m_owner;   // -1 when nobody holds the grant
  int   m_tenure;  // cycles the current grant has been visible
  bit   m_gap;     // a release just happened; next edge does no arbitration
  int   m_ptr;
  bit   m_to;

  function automatic int pick_first(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner  <= -1;
      m_tenure <= 0;
      m_gap    <= 1'b0;
      m_ptr    <= 0;
      m_to     <= 1'b0;
    end else if (m_owner >= 0) begin
      if (done || !req[m_owner] || m_tenure == MAX_HOLD) begin
        m_to    <= !done && req[m_owner];
        m_ptr   <= (m_owner + 1) % 4;
        m_owner <= -1;
        m_gap   <= 1'b1;
      end else begin
        m_to     <= 1'b0;
        m_tenure <= m_tenure + 1;
      end
    end else if (m_gap) begin
      m_gap <= 1'b0;
      m_to  <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (req != 4'b0000) begin
        m_owner  <= pick_first(req, m_ptr);
        m_tenure <= 1;
      end
    end
  end

  logic [7:0] exp_out;
  logic [7:0] obs_out;
  always_comb begin
    exp_out = 8'h00;
    if (m_owner >= 0) begin
      exp_out[7:4] = 4'(1 << m_owner);
      exp_out[3:2] = 2'(m_owner);
      exp_out[1]   = 1'b1;
    end
    exp_out[0] = m_to;
  end
  assign obs_out = {gnt, gnt_idx, gnt_valid, timeout};

  // ---------------- invariant assertions ----------------
  logic prev_timeout = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert ((gnt & (gnt - 4'd1)) == 4'b0000 && gnt_valid == |gnt
              && (!gnt_valid || gnt == 4'(1 << gnt_idx))
              && (gnt_valid || gnt_idx == 2'd0)
              && !(timeout && prev_timeout))
      else begin
        bad++;
        $display("FAIL invariant: gnt=%b gnt_idx=%0d gnt_valid=%b timeout=%b prev_timeout=%b",
                 gnt, gnt_idx, gnt_valid, timeout, prev_timeout);
      end
    end
    prev_timeout = timeout;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    req   = 4'b0000;
    done  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    @(negedge clk);
    total++;
    if (obs_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: got %b want 00000000", obs_out);
    end
    rst_n = 1'b1;
    // Grant, then pull reset mid-cycle: outputs must clear before the edge.
    tick(4'b0001, 1'b0);
    tick(4'b0001, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_async: got %b want 00000000", obs_out);
    end
    $display("reset: outputs=%b", obs_out);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    tick(4'b0100, 1'b0);
    total++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
      bad++;
      $display("FAIL single_grant: gnt=%b idx=%0d want 0100 idx=2", gnt, gnt_idx);
    end
    tick(4'b0100, 1'b0);
    tick(4'b0100, 1'b0);
    tick(4'b0100, 1'b1);
    total++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL single_release: gnt=%b timeout=%b want 0000/0", gnt, timeout);
    end
    tick(4'b0000, 1'b0);
    total++;
    if (obs_out !== exp_out) begin
      bad++;
      $display("FAIL single_idle: got %b want %b", obs_out, exp_out);
    end
    // ptr should now be 3, so with everyone requesting idx 3 wins.
    tick(4'b1111, 1'b0);
    tick(4'b1111, 1'b0);
    total++;
    if (gnt_idx !== 2'd3 || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_ptr: idx=%0d valid=%b want 3/1", gnt_idx, gnt_valid);
    end
    $display("single: grant idx 2 released, next idx=%0d", gnt_idx);
  endtask

  task automatic test_fairness();
    int order[$];
    int ten;
    logic d;
    int want[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    ten = 0;
    d   = 1'b0;
    for (int c = 0; c < 26; c++) begin
      tick(4'b1111, d);
      total++;
      if (obs_out !== exp_out) begin
        bad++;
        $display("FAIL fair_cycle%0d: got %b want %b", c, obs_out, exp_out);
      end
      if (gnt_valid) begin
        if (ten == 0) order.push_back(int'(gnt_idx));
        ten++;
      end else begin
        ten = 0;
      end
      d = (ten == 3);
    end
    total++;
    if (order.size() < 5) begin
      bad++;
      $display("FAIL fair_count: got %0d tenures want 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (order[i] != want[i]) begin
          bad++;
          $display("FAIL fair_order%0d: got %0d want %0d", i, order[i], want[i]);
        end
      end
    end
    $display("fairness: %0d tenures observed", order.size());
  endtask

  task automatic test_timeout();
    int cnt;
    int guard;
    apply_reset();
    tick(4'b0010, 1'b0);
    cnt = 0;
    guard = 0;
    while (gnt_valid && guard < 40) begin
      cnt++;
      guard++;
      total++;
      if (obs_out !== exp_out) begin
        bad++;
        $display("FAIL timeout_cycle%0d: got %b want %b", cnt, obs_out, exp_out);
      end
      if (gnt_valid) tick(4'b0010, 1'b0);
    end
    total++;
    if (cnt != MAX_HOLD || timeout !== 1'b1) begin
      bad++;
      $display("FAIL timeout_len: cycles=%0d timeout=%b want %0d/1", cnt, timeout, MAX_HOLD);
    end
    tick(4'b1010, 1'b0);
    total++;
    if (timeout !== 1'b0 || gnt_valid !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse: timeout=%b valid=%b want 0/0", timeout, gnt_valid);
    end
    tick(4'b1010, 1'b0);
    total++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 2'd3) begin
      bad++;
      $display("FAIL timeout_next: valid=%b idx=%0d want 1/3", gnt_valid, gnt_idx);
    end
    $display("timeout: tenure=%0d cycles, next idx=%0d", cnt, gnt_idx);
  endtask

  task automatic test_done_at_limit();
    apply_reset();
    tick(4'b0001, 1'b0);
    for (int c = 2; c <= MAX_HOLD; c++) tick(4'b0001, 1'b0);
    // Now in tenure cycle 16; done sampled at the limit edge.
    tick(4'b0001, 1'b1);
    total++;
    if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL done_limit: valid=%b timeout=%b want 0/0", gnt_valid, timeout);
    end
    tick(4'b0000, 1'b0);
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL done_limit_late: timeout=%b want 0", timeout);
    end
    $display("done_at_limit: released, timeout=%b", timeout);
  endtask

  task automatic test_drop_and_reset();
    apply_reset();
    tick(4'b1000, 1'b0);
    tick(4'b1000, 1'b0);
    tick(4'b0000, 1'b0);
    total++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL drop_release: gnt=%b timeout=%b want 0000/0", gnt, timeout);
    end
    tick(4'b1111, 1'b0);
    tick(4'b1111, 1'b0);
    total++;
    if (gnt_idx !== 2'd0 || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL drop_ptr: idx=%0d valid=%b want 0/1", gnt_idx, gnt_valid);
    end
    // Release idx 0 so ptr moves to 1, take idx 1, then reset mid-grant.
    tick(4'b1111, 1'b1);
    tick(4'b1111, 1'b0);
    tick(4'b1111, 1'b0);
    total++;
    if (gnt_idx !== 2'd1) begin
      bad++;
      $display("FAIL drop_second: idx=%0d want 1", gnt_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs_out !== 8'h00) begin
      bad++;
      $display("FAIL drop_reset: got %b want 00000000", obs_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(4'b1111, 1'b0);
    total++;
    if (gnt_idx !== 2'd0 || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_ptr: idx=%0d valid=%b want 0/1", gnt_idx, gnt_valid);
    end
    $display("drop_and_reset: post-reset idx=%0d", gnt_idx);
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic d;
    int errs;
    apply_reset();
    errs = 0;
    r = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      // Change requests only occasionally so tenures are long enough to
      // reach the hold limit sometimes.
      if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 15) == 0);
      tick(r, d);
      total++;
      if (obs_out !== exp_out) begin
        bad++;
        errs++;
        if (errs < 10)
          $display("FAIL random_cycle%0d: req=%b done=%b got %b want %b",
                   c, r, d, obs_out, exp_out);
      end
    end
    $display("random: 600 cycles, %0d errors", errs);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_done_at_limit();
    test_drop_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
